// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU definitions for the fetch stage: state encoding, reset PC and word helpers.
package fetch_pc_unit_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-PC selection for the consumed instruction: jr > jump > branch > sequential.
module next_pc_sel
    import fetch_pc_unit_pkg::*;
(
    input  logic [INST_W-1:0] inst_pc_i,
    input  logic              br_taken_i,
    input  logic [31:0]       br_addr_ex_i,
    input  logic              jump_i,
    input  logic [25:0]       jmp_index_i,
    input  logic              jr_i,
    input  logic [31:0]       jr_addr_i,
    output logic [31:0]       next_pc_o
);

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] jmp_pc;

    // Word offset shifted into a byte offset; the top two offset bits fall off, sums wrap mod 2^32.
    assign seq_pc = inst_pc_i + 32'd4;
    assign br_pc  = seq_pc + {br_addr_ex_i[29:0], 2'b00};
    assign jmp_pc = {seq_pc[31:28], jmp_index_i, 2'b00};

    always_comb begin
        next_pc_o = seq_pc;
        if (jr_i) begin
            next_pc_o = jr_addr_i;
        end else if (jump_i) begin
            next_pc_o = jmp_pc;
        end else if (br_taken_i) begin
            next_pc_o = br_pc;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch FSM (FETCH/VALID/DRAIN) with decode handshake.
// Optional misaligned-target reporting on addr_err when FETCH_ALIGN_CHECK_EN is defined.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc,
    input  logic              br_taken,
    input  logic [31:0]       br_addr_ex,
    input  logic              jump,
    input  logic [25:0]       jmp_index,
    input  logic              jr,
    input  logic [31:0]       jr_addr,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    output logic              addr_err
);

    fetch_state_e      state_q;
    logic [31:0]       pc_q;
    logic [31:0]       drain_addr_q;
    logic [INST_W-1:0] inst_q;
    logic [31:0]       inst_pc_q;
    logic              inst_valid_q;
    logic              addr_err_q;

    logic [31:0] next_pc;
    logic [31:0] redirect_raw;
    logic [31:0] pc_d;
    logic        consume;
    logic        misaligned;

    next_pc_sel u_next_pc_sel (
        .inst_pc_i   (inst_pc_q),
        .br_taken_i  (br_taken),
        .br_addr_ex_i(br_addr_ex),
        .jump_i      (jump),
        .jmp_index_i (jmp_index),
        .jr_i        (jr),
        .jr_addr_i   (jr_addr),
        .next_pc_o   (next_pc)
    );

    assign consume      = (state_q == VALID) && inst_ready;
    assign redirect_raw = flush ? flush_pc : next_pc;
    assign pc_d         = word_align(redirect_raw);

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (flush || consume) && (redirect_raw[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            if (misaligned) begin
                addr_err_q <= 1'b1;
            end
            unique case (state_q)
                FETCH: begin
                    if (flush) begin
                        pc_q <= pc_d;
                        // An unanswered request must still complete at the address it was issued with.
                        if (!imem_ready) begin
                            drain_addr_q <= pc_q;
                            state_q      <= DRAIN;
                        end
                    end else if (imem_ready) begin
                        inst_q       <= imem_rdata;
                        inst_pc_q    <= pc_q;
                        inst_valid_q <= 1'b1;
                        state_q      <= VALID;
                    end
                end
                VALID: begin
                    if (flush || consume) begin
                        pc_q         <= pc_d;
                        inst_valid_q <= 1'b0;
                        state_q      <= FETCH;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        pc_q <= pc_d;
                    end
                    if (imem_ready) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign imem_req   = (state_q != VALID);
    assign imem_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign addr_err   = addr_err_q;

endmodule
